// File: rtl/zuc_sbox_pipe_if.sv
// Valid/ready stream bundle for the ZUC S-box engine.
// The upstream and downstream handshakes share one interface.
interface zuc_sbox_pipe_if #(
    parameter int WORDS = 2,
    parameter int TAG_W = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_mode;
    logic [TAG_W-1:0]      in_tag;
    logic [32*WORDS-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [TAG_W-1:0]      out_tag;
    logic [32*WORDS-1:0]   out_data;
    logic                  busy;

    modport master (
        output in_valid, in_mode, in_tag, in_data, out_ready,
        input  in_ready, out_valid, out_tag, out_data, busy
    );

    modport slave (
        input  in_valid, in_mode, in_tag, in_data, out_ready,
        output in_ready, out_valid, out_tag, out_data, busy
    );
endinterface

// File: rtl/zuc_sbox_pipe.sv
// ZUC S0/S1 lookup engine: WORDS lanes, byte-wise table mapping,
// two register stages with valid/ready on both sides.
module zuc_sbox_pipe #(
    parameter int    WORDS     = 2,
    parameter int    TAG_W     = 4,
    parameter string RAM_STYLE = "distributed"
) (
    input logic            clk,
    input logic            rst,
    zuc_sbox_pipe_if.slave bus
);
    localparam int DW = 32 * WORDS;

    localparam logic [2047:0] S0_HEX = {
        128'h3e725b47cae00033_04d1549809b96dcb,
        128'h7b1bf932af9d6aa5_b82dfc1d08530390,
        128'h4d4e8499e4ced991_ddb685488b296eac,
        128'hcdc1f81e734369c6_b5bdfd396320d438,
        128'h767db2a7cfed57c5_f32cbb142106559b,
        128'he3ef5e314f7f5aa4_0d8251495fba581c,
        128'h4a16d517a892241f_8cffd8ae2e01d3ad,
        128'h3b4bda46ebc9de9a_8f87d73a806f2fc8,
        128'hb1b437f70a221328_7ccc3c89c7c39656,
        128'h07bf7ef00b2b9752_35417961a64c10fe,
        128'hbc2695888ab0a3fb_c01894f2e1e5e95d,
        128'hd0dc1166645cec59_427512f5749caa23,
        128'h0e86abbe2a02e767_e644a26cc2939ff1,
        128'hf6fa36d250689e62_71153dd640c4e20f,
        128'h8e83776b25053f0c_30ea70b7a1e8a965,
        128'h8d271adb81b3a0f4_457a19dfee783460
    };

    localparam logic [2047:0] S1_HEX = {
        128'h55c263713bc84786_9f3cda5b29aafd77,
        128'h8cc5940ca61a1300_e3a8167240f9f842,
        128'h4426689681d9453e_1076c6a78b3943e1,
        128'h3ab5562ac06db305_2266bfdc0bfa6248,
        128'hdd20110636c9c1cf_f62752bb69f5d487,
        128'h7f844cd29c57a4bc_4f9adffed68d7aeb,
        128'h2b53d85ca11417fb_23d57d3067730809,
        128'heeb7703f61b2198e_4ee54b938f5ddba9,
        128'hadf1ae2ecb0dfcf4_2d466e1d97e8d1e9,
        128'h4d37a5755e839eab_829db91ce0cd4989,
        128'h01b6bd5824a25f38_7899159050b895e4,
        128'hd091c7ceed0fb46f_a0ccf0024a79c3de,
        128'ha3efea51e66b18ec_1b2c80f774e7ff21,
        128'h5a6a541e41319235_c433070aba7e0e34,
        128'h88b1987cf33d606c_7bcad31f32650428,
        128'h64be859b2f598ad7_b025acaf1203e2f2
    };

    logic             a_valid;
    logic             b_valid;
    logic             a_adv;
    logic             b_adv;
    logic             a_load;
    logic [1:0]       a_mode;
    logic [TAG_W-1:0] a_tag;
    logic [DW-1:0]    a_data;
    logic [DW-1:0]    b_nxt;
    logic [DW-1:0]    b_data;
    logic [TAG_W-1:0] b_tag;

    assign b_adv  = !b_valid || bus.out_ready;
    assign a_adv  = !a_valid || b_adv;
    assign a_load = bus.in_valid && a_adv;

    assign bus.in_ready  = a_adv;
    assign bus.out_valid = b_valid;
    assign bus.out_data  = b_data;
    assign bus.out_tag   = b_tag;
    assign bus.busy      = a_valid | b_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            b_data  <= '0;
            b_tag   <= '0;
        end else begin
            if (a_adv)
                a_valid <= bus.in_valid;
            if (b_adv)
                b_valid <= a_valid;
            if (b_adv && a_valid) begin
                b_data <= b_nxt;
                b_tag  <= a_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (a_load) begin
            a_mode <= bus.in_mode;
            a_tag  <= bus.in_tag;
            a_data <= bus.in_data;
        end
    end

    for (genvar w = 0; w < WORDS; w++) begin : g_word
        (* ram_style = RAM_STYLE *) logic [7:0] s0_rom [256];
        (* ram_style = RAM_STYLE *) logic [7:0] s1_rom [256];

        for (genvar i = 0; i < 256; i++) begin : g_init
            assign s0_rom[i] = S0_HEX[2047-8*i -: 8];
            assign s1_rom[i] = S1_HEX[2047-8*i -: 8];
        end

        for (genvar b = 0; b < 4; b++) begin : g_byte
            localparam int  LO     = 32 * w + 8 * b;
            localparam bit  ODD_B  = (b % 2 == 1);
            logic [7:0] s0_q;
            logic [7:0] s1_q;
            logic [7:0] lane;

            // Read only on load so a stalled stage A keeps its bytes.
            always_ff @(posedge clk) begin
                if (a_load) begin
                    s0_q <= s0_rom[bus.in_data[LO +: 8]];
                    s1_q <= s1_rom[bus.in_data[LO +: 8]];
                end
            end

            always_comb begin
                lane = a_data[LO +: 8];
                unique case (a_mode)
                    2'd0:    lane = ODD_B ? s0_q : s1_q;
                    2'd1:    lane = s0_q;
                    2'd2:    lane = s1_q;
                    default: lane = a_data[LO +: 8];
                endcase
            end

            assign b_nxt[LO +: 8] = lane;
        end
    end
endmodule

// File: doc/zuc_sbox_pipe.md
Name: zuc_sbox_pipe

Overview:
Multi-lane, pipelined ZUC S-box lookup engine with valid/ready handshaking on both sides. It maps WORDS 32-bit words per transaction byte-wise through the ZUC S0 and S1 tables, under a per-transaction mode. It carries a sideband tag and supports full throughput under backpressure. It replaces the fixed two-port S0 ROM as the lookup resource for the nonlinear function F and for key-schedule and test paths.

Parameters:
WORDS, 2, number of 32-bit words per transaction (legal 1..8); each word owns its own S0/S1 table copies.
TAG_W, 4, width of sideband tag carried with each transaction (legal 1..16).
RAM_STYLE, "distributed", synthesis ram_style attribute applied to every S0/S1 table instance.

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  upstream transaction valid.
in_ready  out  1  engine can accept this cycle.
in_mode  in  2  0=ZUC pattern (S0,S1,S0,S1 from MSB byte), 1=all S0, 2=all S1, 3=bypass.
in_tag  in  TAG_W  sideband, returned unchanged.
in_data  in  32*WORDS  word k at bits [32k+31:32k].
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts.
out_tag  out  TAG_W  tag of result.
out_data  out  32*WORDS  transformed words, same packing as in_data.
busy  out  1  high when any pipeline stage holds a transaction.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Tables: S0 and S1 contents exactly per the ZUC specification. Spot values: S0[0x00]=0x3e, S0[0x01]=0x72, S0[0xff]=0x60, S1[0x00]=0x55, S1[0x01]=0xc2. Tables are read-only and initialised at elaboration.
- Pipeline: two registered stages.
  - Stage A: synchronous table read; registers looked-up bytes, mode, tag and original data (for bypass).
  - Stage B: output register; selects bypass or looked-up bytes per mode.
- Byte mapping, per word, byte 3 = bits [31:24]:
  - mode 0: {S0[b3],S1[b2],S0[b1],S1[b0]}
  - mode 1: S0 on all bytes
  - mode 2: S1 on all bytes
  - mode 3: output = input
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - Stage B advances when !out_valid || out_ready.
  - Stage A advances when !a_valid || B advances.
  - in_ready = !a_valid || B advances (combinational from out_ready; no combinational path from in_valid to in_ready).
- Latency and throughput:
  - With out_ready held high, a transaction accepted at edge t presents out_valid at edge t+2.
  - Throughput is one transaction per cycle.
- Backpressure: when out_ready is low, out_valid, out_data and out_tag hold stable until accepted. Stage A holds, then in_ready falls. No transaction is dropped or duplicated, and order is preserved.
- Simultaneous events: accept at input, move A->B and pop at output may all happen on one edge. Occupancy never exceeds 2 transactions.
- Table read enable: asserted only when stage A loads, so table outputs for a stalled A are not disturbed.
- Reset values:
  - a_valid=0, out_valid=0, busy=0, out_data=0, out_tag=0.
  - in_ready=1 during and after reset.
- Reset mid-operation: all in-flight transactions are discarded. No out_valid appears in the cycle after rst deasserts unless new input was accepted.
- busy = a_valid | out_valid.

Test Plan:
- mode 1, word0=0x00000000, word1=0x01ff0600, out_ready=1 -> two cycles later out_data word0=0x3e3e3e3e, word1=0x7260003e, tag echoed.
- mode 0 and mode 2, data 0x00000000 on all words -> mode 0 gives 0x3e553e55; mode 2 gives 0x55555555; mode 3 with 0x12345678 gives 0x12345678.
- Streaming: 16 back-to-back transactions, tags 0..15, out_ready=1 -> in_ready never drops; outputs in order one per cycle starting 2 cycles after first accept.
- Backpressure: out_ready low for 5 cycles during a stream -> out_data and out_tag stable while out_valid=1; in_ready drops after 2 buffered; all tags later delivered once in order; random out_ready 10k transactions checked against a reference model.
- Reset: assert rst for 1 cycle with 2 transactions in flight -> next cycle out_valid=0, busy=0, in_ready=1, out_data=0; a subsequent transaction is processed normally.
- Exhaustive per-byte check: sweep 0x00..0xff in every byte lane and every word under modes 1 and 2 -> all 256 entries of S0 and S1 match the specification table.
